// File: rtl/pp_sum_pipe_pkg.sv
// Shared constants for the partial-product summing pipeline.
// Holds the default operand width, the accumulator width rule and the mode encoding.
package pp_sum_pipe_pkg;

  localparam int DEFAULT_W = 16;

  localparam logic MODE_PLAIN = 1'b0;
  localparam logic MODE_ACC   = 1'b1;

  // Eight guard bits above the full product give 256 worst-case additions before wrap.
  function automatic int acc_width(input int w);
    return 2 * w + 8;
  endfunction

endpackage

// File: rtl/pp_sum_pipe_if.sv
// Input and output handshake bundle of pp_sum_pipe.
// The slave modport is the pipeline side; the master modport is the producer/consumer side.
interface pp_sum_pipe_if
  import pp_sum_pipe_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int ACC_W = acc_width(W)
);

  logic [W-1:0]     prod1;
  logic [W-1:0]     prod2;
  logic [W-1:0]     prod3;
  logic [W-1:0]     prod4;
  logic             in_mode;
  logic             in_clr;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             acc_ovf;

  modport master (
    output prod1, prod2, prod3, prod4, in_mode, in_clr, in_valid, out_ready,
    input  in_ready, out_data, out_valid, acc_ovf
  );

  modport slave (
    input  prod1, prod2, prod3, prod4, in_mode, in_clr, in_valid, out_ready,
    output in_ready, out_data, out_valid, acc_ovf
  );

endinterface

// File: rtl/pp_stage_reg.sv
// One valid/ready pipeline slot holding a payload of PW bits.
// The slot can refill in the same cycle it drains, so a full chain streams at one beat per cycle.
module pp_stage_reg #(
  parameter int PW         = 8,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [PW-1:0] out_data_o
);

  logic          valid_q;
  logic          valid_d;
  logic [PW-1:0] data_q;
  logic [PW-1:0] data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
    end
    if (in_valid_i && in_ready_o) begin
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload only clears when this slot drives a visible output.
  always_ff @(posedge clk) begin
    if (rst && RESET_DATA) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pp_sum_pipe.sv
// Two-stage pipeline that recombines four half-width partial products into a full product
// and either emits it directly or folds it into a running accumulator with a sticky overflow flag.
module pp_sum_pipe
  import pp_sum_pipe_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int ACC_W = acc_width(W)
) (
  input logic          clk,
  input logic          rst,
  pp_sum_pipe_if.slave bus
);

  // Stage-1 payload, LSB first: mid[W:0], lo, hi, clr, mode.
  localparam int PW1 = 3 * W + 3;

  logic             s1_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [W:0]       mid_in;
  logic [PW1-1:0]   s1_in;
  logic [PW1-1:0]   s1_data;

  logic [W:0]       s1_mid;
  logic [W-1:0]     s1_lo;
  logic [W-1:0]     s1_hi;
  logic             s1_clr;
  logic             s1_mode;

  logic [2*W-1:0]   prod_full;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] result;
  logic             acc_update;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_q;
  logic             ovf_d;

  assign mid_in = {1'b0, bus.prod2} + {1'b0, bus.prod3};
  assign s1_in  = {bus.in_mode, bus.in_clr, bus.prod4, bus.prod1, mid_in};

  assign s1_mid  = s1_data[W:0];
  assign s1_lo   = s1_data[2*W:W+1];
  assign s1_hi   = s1_data[3*W:2*W+1];
  assign s1_clr  = s1_data[3*W+1];
  assign s1_mode = s1_data[3*W+2];

  pp_stage_reg #(
    .PW         (PW1),
    .RESET_DATA (1'b0)
  ) u_stage1 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (s1_adv),
    .in_data_i   (s1_in),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_adv),
    .out_data_o  (s1_data)
  );

  assign bus.in_ready = s1_adv;

  // The middle partial products overlap the low and high halves by W/2 bits.
  assign prod_full  = {s1_hi, s1_lo} + ((2 * W)'(s1_mid) << (W / 2));
  assign prod_ext   = ACC_W'(prod_full);
  assign acc_base   = s1_clr ? '0 : acc_q;
  assign acc_sum    = {1'b0, acc_base} + {1'b0, prod_ext};
  assign result     = (s1_mode == MODE_ACC) ? acc_sum[ACC_W-1:0] : prod_ext;
  assign acc_update = s1_valid && s2_adv && (s1_mode == MODE_ACC);

  pp_stage_reg #(
    .PW         (ACC_W),
    .RESET_DATA (1'b1)
  ) u_stage2 (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_adv),
    .in_data_i   (result),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (bus.out_data)
  );

  // A clearing beat restarts the overflow history; otherwise the flag is sticky.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (acc_update) begin
      acc_d = acc_sum[ACC_W-1:0];
      ovf_d = s1_clr ? acc_sum[ACC_W] : (ovf_q | acc_sum[ACC_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.acc_ovf = ovf_q;

endmodule

// File: tb/tb_pp_sum_pipe.sv
// Directed and randomized bench for pp_sum_pipe (W=16, ACC_W=40) against an arithmetic model.
module tb_pp_sum_pipe;

  typedef struct {
    logic [39:0] data;
    logic        ovf;
  } exp_t;

  localparam logic [15:0] FE = 16'hFE01;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   acceptedCount;
  int   outCount;

  exp_t        expQ[$];
  logic [39:0] logData[$];
  logic        logOvf[$];
  logic [63:0] modelAcc;
  logic        modelOvf;
  logic        stallHeld;
  logic [39:0] stallData;

  pp_sum_pipe_if #(.W(16), .ACC_W(40)) bus ();

  pp_sum_pipe #(.W(16), .ACC_W(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full product from the four partial products by plain positional arithmetic.
  function automatic logic [63:0] refProduct(input logic [15:0] q1, input logic [15:0] q2,
                                             input logic [15:0] q3, input logic [15:0] q4);
    logic [63:0] s;
    s = 64'(q1) + ((64'(q2) + 64'(q3)) * 64'd256) + (64'(q4) * 64'd65536);
    return s % 64'h1_0000_0000;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] q1, input logic [15:0] q2,
                               input logic [15:0] q3, input logic [15:0] q4,
                               input logic m, input logic c);
    bus.in_valid = v;
    bus.prod1    = q1;
    bus.prod2    = q2;
    bus.prod3    = q3;
    bus.prod4    = q4;
    bus.in_mode  = m;
    bus.in_clr   = c;
  endtask

  task automatic modelAccept();
    exp_t        e;
    logic [63:0] p;
    logic [63:0] s;
    p = refProduct(bus.prod1, bus.prod2, bus.prod3, bus.prod4);
    if (bus.in_mode == 1'b0) begin
      e.data = p[39:0];
      e.ovf  = modelOvf;
    end else begin
      s        = (bus.in_clr ? 64'd0 : modelAcc) + p;
      modelOvf = bus.in_clr ? (s >= 64'h100_0000_0000) : (modelOvf | (s >= 64'h100_0000_0000));
      modelAcc = s % 64'h100_0000_0000;
      e.data   = modelAcc[39:0];
      e.ovf    = modelOvf;
    end
    expQ.push_back(e);
    acceptedCount++;
  endtask

  task automatic checkOutput();
    exp_t e;
    checkVal("in_ready", 64'(bus.in_ready), 64'(!(expQ.size() == 2 && !bus.out_ready)));
    if (bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checkVal("spurious_out", 64'(bus.out_valid), 64'd0);
      end else begin
        e = expQ.pop_front();
        checkVal("out_data", 64'(bus.out_data), 64'(e.data));
        checkVal("acc_ovf", 64'(bus.acc_ovf), 64'(e.ovf));
      end
      logData.push_back(bus.out_data);
      logOvf.push_back(bus.acc_ovf);
      outCount++;
    end
    if (bus.out_valid && !bus.out_ready) begin
      if (stallHeld) begin
        checkVal("stall_hold", 64'(bus.out_data), 64'(stallData));
      end else begin
        stallHeld = 1'b1;
        stallData = bus.out_data;
      end
    end else begin
      stallHeld = 1'b0;
    end
  endtask

  // One clock: sample mid-cycle, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      expQ.delete();
      modelAcc  = '0;
      modelOvf  = 1'b0;
      stallHeld = 1'b0;
    end else begin
      checkOutput();
      if (bus.in_valid && bus.in_ready) modelAccept();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic [15:0] q1, input logic [15:0] q2, input logic [15:0] q3,
                          input logic [15:0] q4, input logic m, input logic c);
    int startAcc;
    startAcc = acceptedCount;
    applyStimulus(1'b1, q1, q2, q3, q4, m, c);
    for (int k = 0; k < 50 && acceptedCount == startAcc; k++) tick();
    bus.in_valid = 1'b0;
    checkVal("accept_bound", 64'(acceptedCount - startAcc), 64'd1);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && expQ.size() != 0; k++) tick();
    checkVal("drain_bound", 64'(expQ.size()), 64'd0);
    tick();
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q[4];
    int          base;
    int          idx;

    checks        = 0;
    errors        = 0;
    acceptedCount = 0;
    outCount      = 0;
    modelAcc      = '0;
    modelOvf      = 1'b0;
    stallHeld     = 1'b0;
    stallData     = '0;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    checkVal("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkVal("rst_acc_ovf", 64'(bus.acc_ovf), 64'd0);
    checkVal("rst_out_data", 64'(bus.out_data), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] plain product and latency");
    sendBeat(FE, FE, FE, FE, 1'b0, 1'b0);
    checkVal("lat_cycle1", 64'(bus.out_valid), 64'd0);
    tick();
    checkVal("lat_cycle2", 64'(bus.out_valid), 64'd1);
    checkVal("plain_fe01", 64'(bus.out_data), 64'h00FFFE0001);
    drain();
    logData.delete();
    sendBeat(FE, FE, FE, FE, 1'b1, 1'b0);
    drain();
    checkVal("acc_untouched", 64'(logData[0]), 64'hFFFE0001);

    $display("[TB] three accumulate beats");
    logData.delete();
    logOvf.delete();
    sendBeat(FE, FE, FE, FE, 1'b1, 1'b1);
    sendBeat(FE, FE, FE, FE, 1'b1, 1'b0);
    sendBeat(FE, FE, FE, FE, 1'b1, 1'b0);
    drain();
    checkVal("acc3_n", 64'(logData.size()), 64'd3);
    checkVal("acc3_0", 64'(logData[0]), 64'hFFFE0001);
    checkVal("acc3_1", 64'(logData[1]), 64'h1FFFC0002);
    checkVal("acc3_2", 64'(logData[2]), 64'h2FFFA0003);
    checkVal("acc3_ovf", 64'(logOvf[2]), 64'd0);

    $display("[TB] 257 accumulate beats");
    logData.delete();
    logOvf.delete();
    for (int i = 0; i < 257; i++) sendBeat(FE, FE, FE, FE, 1'b1, (i == 0));
    drain();
    checkVal("acc257_n", 64'(logData.size()), 64'd257);
    checkVal("acc256_data", 64'(logData[255]), 64'hFFFE000100);
    checkVal("acc256_ovf", 64'(logOvf[255]), 64'd0);
    checkVal("acc257_data", 64'(logData[256]), 64'h00FDFE0101);
    checkVal("acc257_ovf", 64'(logOvf[256]), 64'd1);

    $display("[TB] plain beat between accumulate beats");
    logData.delete();
    logOvf.delete();
    sendBeat(FE, FE, FE, FE, 1'b1, 1'b1);
    sendBeat(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b0, 1'b1);
    sendBeat(FE, FE, FE, FE, 1'b1, 1'b0);
    drain();
    checkVal("mix_first", 64'(logData[0]), 64'hFFFE0001);
    checkVal("mix_ovf_clr", 64'(logOvf[0]), 64'd0);
    checkVal("mix_last", 64'(logData[2]), 64'h1FFFC0002);
    checkVal("mix_last_ovf", 64'(logOvf[2]), 64'd0);

    $display("[TB] output stall");
    bus.out_ready = 1'b0;
    base = acceptedCount;
    for (int c = 0; c < 5; c++) begin
      idx = acceptedCount - base;
      if (idx < 3) applyStimulus(1'b1, 16'(idx + 1), 16'(3 * idx), 16'h00FF, 16'(idx), 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      tick();
    end
    checkVal("stall_accepts", 64'(acceptedCount - base), 64'd2);
    checkVal("stall_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    base = outCount;
    for (int c = 0; c < 3; c++) begin
      if (acceptedCount - base == 0 && bus.in_valid) begin
        bus.in_valid = bus.in_valid;
      end
      tick();
      if (expQ.size() + outCount - base >= 3) bus.in_valid = 1'b0;
    end
    checkVal("release_gapless", 64'(outCount - base), 64'd3);
    checkVal("release_empty", 64'(expQ.size()), 64'd0);
    drain();

    $display("[TB] reset with both stages full");
    bus.out_ready = 1'b0;
    sendBeat(FE, FE, FE, FE, 1'b1, 1'b1);
    sendBeat(FE, FE, FE, FE, 1'b1, 1'b0);
    tick();
    checkVal("full_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    checkVal("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("mid_rst_acc_ovf", 64'(bus.acc_ovf), 64'd0);
    checkVal("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    logData.delete();
    sendBeat(16'h0002, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    drain();
    checkVal("post_rst_acc", 64'(logData[0]), 64'h2);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 300; c++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      q[0] = {8'h0, a[7:0]} * {8'h0, b[7:0]};
      q[1] = {8'h0, a[7:0]} * {8'h0, b[15:8]};
      q[2] = {8'h0, a[15:8]} * {8'h0, b[7:0]};
      q[3] = {8'h0, a[15:8]} * {8'h0, b[15:8]};
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 4; k++) q[k] = 16'($urandom);
      end
      applyStimulus(($urandom_range(0, 3) != 0), q[0], q[1], q[2], q[3],
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
